// File: rtl/fp_add_scheduler.sv
// rtl/fp_add_scheduler.sv - round-robin scheduler sharing one external multicycle fp32 adder
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester operand handshake (ready one-hot or zero)
//   req_a, req_b            packed operand pairs, requester i in bits [32i+31:32i]
//   rsp_valid/rsp_ready     per-requester result handshake (valid one-hot or zero)
//   rsp_data, rsp_signerr   shared result and its sign-error qualifier
//   add_a, add_b, add_out   registered adder operands and combinational adder result
//   busy                    high outside IDLE
//   op_count                saturating count of accepted responses
module fp_add_scheduler #(
    parameter int NREQ = 2,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_signerr,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    input  logic [31:0]       add_out,
    output logic              busy,
    output logic [15:0]       op_count
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q;
    logic [IW-1:0]     last_q;
    logic [IW-1:0]     grant_q;
    logic [3:0]        cnt_q;
    logic [31:0]       opa_q;
    logic [31:0]       opb_q;
    logic [31:0]       result_q;
    logic              signerr_q;
    logic              busy_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [15:0]       op_count_q;
    logic [15:0]       op_count_d;

    logic [IW-1:0]     gsel;
    logic              found;
    logic [IW-1:0]     idx;
    logic [31:0]       a_arr [NREQ];
    logic [31:0]       b_arr [NREQ];

    // Unpack operand buses so the selected pair can be indexed by gsel.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[i*32 +: 32];
            b_arr[i] = req_b[i*32 +: 32];
        end
    end

    // Round-robin search starting just after the last serviced requester.
    always_comb begin
        gsel  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last_q) + i) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gsel  = idx;
            end
        end
    end

    // Ready is forced low during reset since state alone cannot express that.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && found) begin
            req_ready[gsel] = 1'b1;
        end
    end

    always_comb begin
        op_count_d = (op_count_q == 16'hFFFF) ? op_count_q : op_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IW'(NREQ - 1);
            grant_q     <= '0;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            signerr_q   <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        opa_q   <= a_arr[gsel];
                        opb_q   <= b_arr[gsel];
                        grant_q <= gsel;
                        cnt_q   <= 4'(LAT - 1);
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // add_out is only trusted on the final settle cycle.
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        result_q    <= add_out;
                        signerr_q   <= opa_q[31] | opb_q[31];
                        rsp_valid_q <= NREQ'(1) << grant_q;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_q]) begin
                        rsp_valid_q <= '0;
                        last_q      <= grant_q;
                        busy_q      <= 1'b0;
                        op_count_q  <= op_count_d;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign add_a       = opa_q;
    assign add_b       = opb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = result_q;
    assign rsp_signerr = signerr_q;
    assign busy        = busy_q;
    assign op_count    = op_count_q;

endmodule

// File: doc/fp_add_scheduler.md
# fp_add_scheduler

Shares one combinational single-precision floating-point adder between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block picks one requester round-robin, registers its operands onto the adder inputs, and holds them for LAT cycles as a multicycle path. It then captures the sum and returns it to the same requester with a valid/ready handshake. It sits between the client blocks and the adder datapath, and the adder is instantiated outside this block.

## Interface
Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- LAT, 2, multicycle settle cycles allowed for the adder; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester operand accept; at most one bit high.
- req_a  in  NREQ*32  operand A of requester i in bits [32i+31:32i].
- req_b  in  NREQ*32  operand B, same packing.
- rsp_valid  out  NREQ  result valid; at most one bit high.
- rsp_ready  in  NREQ  per-requester result accept.
- rsp_data  out  32  result, shared by all requesters.
- rsp_signerr  out  1  qualifies rsp_data; set when either captured operand had bit 31 = 1. The adder handles positive operands only, so the result is not meaningful.
- add_a  out  32  to adder operand A; driven from the operand register.
- add_b  out  32  to adder operand B; driven from the operand register.
- add_out  in  32  adder result, combinational from add_a and add_b.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  count of completed responses; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Round-robin pointer `last` holds the index of the last serviced requester (width clog2(NREQ)).
  - Search order is last+1, last+2, … modulo NREQ.
  - The first requester in that order with req_valid = 1 is `gsel`.
- IDLE:
  - req_ready[gsel] = 1, combinational from req_valid and last. All other ready bits are 0.
  - If no requester is valid, req_ready = 0.
  - Handshake on edge: operand registers <= req_a/req_b slices of gsel, grant <= gsel, cnt <= LAT-1, go to EXEC.
- EXEC:
  - req_ready = 0.
  - add_a and add_b stay stable from the operand registers.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: result <= add_out, rsp_signerr <= a[31] | b[31], go to RESP.
- RESP:
  - rsp_valid[grant] = 1 and rsp_data = result, both held stable until accepted.
  - rsp_ready bits other than rsp_ready[grant] are ignored.
  - On rsp_ready[grant]: last <= grant, op_count increments (saturating), go to IDLE.
- A requester may deassert req_valid at any time before its handshake with no effect. There is no commitment until the handshake.
- Operands are forwarded unmodified. A sign bit set does not block the operation; it only raises rsp_signerr.

## Timing
- Reset, asynchronous and immediate:
  - State = IDLE, last = NREQ-1 so requester 0 has first priority.
  - Operand registers, result, cnt = 0, so add_a = add_b = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_signerr = 0, busy = 0, op_count = 0.
  - req_ready is combinational and is 0 while rst_n = 0.
- Reset mid-EXEC or mid-RESP: the in-flight operation is discarded, no response is issued, and the pointer returns to NREQ-1.
- Latency, with handshake at edge k:
  - EXEC occupies cycles k+1 … k+LAT.
  - rsp_valid is high from cycle k+LAT+1.
  - The earliest next handshake is at the edge ending the first IDLE cycle after response acceptance.
  - Peak throughput is one operation per LAT+2 cycles.
- add_out is sampled only at the edge ending the last EXEC cycle. Downstream timing must treat add_a → add_out as a LAT-cycle multicycle path.
- Simultaneous request and response activity cannot occur, because req_ready = 0 outside IDLE.
- Requests arriving during EXEC or RESP wait; they are arbitrated in the next IDLE cycle.
- op_count at 16'hFFFF stays at 16'hFFFF.

## Test plan
- Single op, NREQ=2, LAT=2:
  - Stimulus: req0 a = 0x3F800000, b = 0x40000000, rsp_ready[0] = 1.
  - Required: handshake at edge 0; rsp_valid[0] high in cycle 3; rsp_data = 0x40400000; rsp_signerr = 0; op_count = 1.
- Round-robin:
  - Stimulus: both requesters continuously valid.
    - req0 a = 0x3F800000, b = 0x3F800000.
    - req1 a = 0x40000000, b = 0x40000000.
  - Required: grant order 0, 1, 0, 1.
    - Responses alternate 0x40000000 (to req0) and 0x40800000 (to req1).
    - No requester is ever granted twice in a row.
- Backpressure:
  - Stimulus: rsp_ready[0] held 0 for 10 cycles in RESP; req1 valid throughout.
  - Required: rsp_valid[0] and rsp_data stable; busy = 1; req_ready = 0.
    - Response accepted on the edge rsp_ready[0] = 1; req1 granted in the following IDLE cycle.
- Sign error:
  - Stimulus: a = 0xBF800000, b = 0x3F800000.
  - Required: rsp_signerr = 1 with the response; op_count increments.
- Reset mid-EXEC:
  - Stimulus: rst_n pulled low during the second EXEC cycle.
  - Required: rsp_valid never asserts; busy = 0; add_a = 0.
    - After release, with both requesters valid, requester 0 is granted first.
- Saturation:
  - Stimulus: force op_count to 16'hFFFE via a hierarchical deposit, then complete three operations.
  - Required: op_count reads 0xFFFF, 0xFFFF, 0xFFFF after the three operations.
